// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller.
// The optional input synchronizer is enabled with the STOPWATCH_SYNC_EN macro.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } sw_state_t;

   localparam int CNT_BITS_DEF = 16;

   // RUN and LAP are the two states in which time advances.
   function automatic logic is_counting(input sw_state_t s);
      return (s == RUN) || (s == LAP);
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Button rising-edge detector with an optional 2-flop synchronizer in front.
// The synchronizer is present when STOPWATCH_SYNC_EN is defined.
module btn_edge (
   input  logic clk,
   input  logic n_rst,
   input  logic i_level,
   output logic o_pulse
);

   logic w_level;
   logic r_prev;

`ifdef STOPWATCH_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   // Two-stage synchronizer for an asynchronous button level.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_level;
         r_sync2 <= r_sync1;
      end
   end

   assign w_level = r_sync2;
`else
   assign w_level = i_level;
`endif

   // Previous level, used to turn a held button into a single pulse.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_level;
      end
   end

   assign o_pulse = w_level & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences divider/counter enables, lap freeze, clear
// and optional saturation. Uses btn_edge (STOPWATCH_SYNC_EN adds synchronizers).
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int   CNT_BITS = CNT_BITS_DEF,
   parameter logic SATURATE = 1'b1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start_stop,
   input  logic                lap,
   input  logic                clr,
   input  logic                tick,
   input  logic [CNT_BITS-1:0] count_in,
   output logic                div_enable,
   output logic                cnt_enable,
   output logic                cnt_clear,
   output logic [CNT_BITS-1:0] disp_value,
   output logic                running,
   output logic                lap_active
);

   logic w_ev_ss;
   logic w_ev_lap;
   logic w_ev_clr;

   sw_state_t r_state;
   sw_state_t w_next;

   logic [CNT_BITS-1:0] r_lap_reg;
   logic                w_lap_load;
   logic                w_clr_accept;
   logic                r_cnt_clear;
   logic                r_running;
   logic                r_lap_active;
   logic                w_counting;
   logic                w_sat;

   btn_edge u_edge_ss  (.clk(clk), .n_rst(n_rst), .i_level(start_stop), .o_pulse(w_ev_ss));
   btn_edge u_edge_lap (.clk(clk), .n_rst(n_rst), .i_level(lap),        .o_pulse(w_ev_lap));
   btn_edge u_edge_clr (.clk(clk), .n_rst(n_rst), .i_level(clr),        .o_pulse(w_ev_clr));

   assign w_counting = is_counting(r_state);
   assign w_sat      = (SATURATE == 1'b1) && tick && w_counting && (&count_in);

   // Next-state decode; the highest-priority event present is the only one considered.
   always_comb begin
      w_next       = r_state;
      w_lap_load   = 1'b0;
      w_clr_accept = 1'b0;
      if (w_sat) begin
         w_next = PAUSE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ev_clr) begin
                  w_next       = IDLE;
                  w_clr_accept = 1'b1;
               end else if (w_ev_ss) begin
                  w_next = RUN;
               end else begin
                  w_next = IDLE;
               end
            end
            RUN: begin
               if (w_ev_clr) begin
                  w_next = RUN;
               end else if (w_ev_ss) begin
                  w_next = PAUSE;
               end else if (w_ev_lap) begin
                  w_next     = LAP;
                  w_lap_load = 1'b1;
               end else begin
                  w_next = RUN;
               end
            end
            LAP: begin
               if (w_ev_clr) begin
                  w_next = LAP;
               end else if (w_ev_ss) begin
                  w_next = PAUSE;
               end else if (w_ev_lap) begin
                  w_next = RUN;
               end else begin
                  w_next = LAP;
               end
            end
            PAUSE: begin
               if (w_ev_clr) begin
                  w_next       = IDLE;
                  w_clr_accept = 1'b1;
               end else if (w_ev_ss) begin
                  w_next = RUN;
               end else begin
                  w_next = PAUSE;
               end
            end
            default: begin
               w_next = IDLE;
            end
         endcase
      end
   end

   // State and state-derived outputs, registered from the next state so they track r_state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= IDLE;
         r_running    <= 1'b0;
         r_lap_active <= 1'b0;
         r_cnt_clear  <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_running    <= is_counting(w_next);
         r_lap_active <= (w_next == LAP);
         r_cnt_clear  <= w_clr_accept;
      end
   end

   // Lap snapshot taken on the RUN->LAP edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_lap_reg <= '0;
      end else if (w_lap_load) begin
         r_lap_reg <= count_in;
      end else begin
         r_lap_reg <= r_lap_reg;
      end
   end

   // Enable follows tick combinationally so it lines up with the divider pulse.
   assign cnt_enable = tick & w_counting & ~w_sat;
   assign div_enable = r_running;
   assign running    = r_running;
   assign lap_active = r_lap_active;
   assign cnt_clear  = r_cnt_clear;
   assign disp_value = r_lap_active ? r_lap_reg : count_in;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the divider/counter/hex-display datapath as a stopwatch.
- Takes debounced, active-high button levels (start/stop, lap, clear) and the divider's one-cycle tick.
- Drives the divider enable, the counter enable/clear, and the value presented to the hex decoders.
- Adds lap-freeze and optional saturation at full count.

Parameters:
- CNT_BITS, 16, width of count_in, lap register and disp_value.
- SATURATE, 1, 1 = auto-pause when the count reaches all-ones; 0 = allow the counter to wrap.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- start_stop  input  1  button level, high = pressed
- lap  input  1  button level, high = pressed
- clr  input  1  button level, high = pressed
- tick  input  1  one-cycle pulse from the divider's rollover flag
- count_in  input  CNT_BITS  counter's current count_out
- div_enable  output  1  count_enable for the divider counter
- cnt_enable  output  1  count_enable for the display counter
- cnt_clear  output  1  synchronous clear for the display counter
- disp_value  output  CNT_BITS  value routed to the hex decoders
- running  output  1  high in RUN or LAP
- lap_active  output  1  high in LAP

Behaviour:
- Reset (n_rst low, async):
  - state = IDLE; lap_reg = 0; cnt_clear = 0; all button edge registers = 0.
  - div_enable = 0, cnt_enable = 0, running = 0, lap_active = 0, disp_value = count_in.
- Button events:
  - Each event is the rising edge of its level, detected against a registered previous value.
  - An event is a 1-cycle pulse in the cycle the level is first seen high.
  - Holding a button produces exactly one event.
- Priority when events coincide: clr > start_stop > lap. Lower-priority events in the same cycle are dropped, not queued.
- States: IDLE, RUN, LAP, PAUSE.
  - IDLE: start_stop -> RUN. lap ignored. clr -> IDLE and re-asserts cnt_clear.
  - RUN: start_stop -> PAUSE. lap -> LAP, capturing count_in into lap_reg that same edge. clr ignored.
  - LAP: lap -> RUN. start_stop -> PAUSE, and the display returns to live. clr ignored. Counting continues underneath.
  - PAUSE: start_stop -> RUN. clr -> IDLE. lap ignored.
- cnt_clear:
  - Registered 1-cycle pulse, asserted the cycle after a clr event is accepted (PAUSE->IDLE or IDLE->IDLE).
  - Never asserted together with cnt_enable.
- Enables:
  - div_enable is registered: high exactly while the state is RUN or LAP.
  - cnt_enable = tick AND (state RUN or LAP). Combinational from tick, so it stays aligned with the divider pulse.
  - A tick arriving in the same cycle as a start_stop event from RUN still counts (the state is sampled pre-transition).
- disp_value = lap_active ? lap_reg : count_in. Combinational mux.
- Saturation (SATURATE = 1):
  - If state is RUN/LAP, tick = 1 and count_in = all-ones: cnt_enable is forced 0 and the next state is PAUSE.
  - The display holds all-ones; start_stop from this PAUSE re-enters RUN but is immediately re-paused on the next tick.
- SATURATE = 0: the counter wraps to 0 with no FSM reaction.
- Latency: state and registered outputs update 1 clk after the button edge is sampled.

Optional Feature:
- Macro: STOPWATCH_SYNC_EN.
- Defined: each of start_stop, lap and clr passes through a 2-flop synchronizer (reset to 0) before edge detection. Event latency grows by 2 clk.
- Undefined: inputs feed edge detection directly. The inputs must then already be synchronous to clk.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} sw_state_t
  - localparam default CNT_BITS
- One sub-module, btn_edge: optional synchronizer plus rising-edge pulse. It is instantiated three times.

Test Plan:
- Reset, then start_stop high for 5 cycles -> exactly one transition to RUN; div_enable = 1 from the next cycle; running = 1.
- RUN, tick every 4 clk, count_in driven 0x0010 -> cnt_enable pulses coincide with tick; lap press at 0x0012 -> lap_active = 1, disp_value stays 0x0012 while count_in advances to 0x0015; second lap -> disp_value = 0x0015 live.
- RUN, start_stop and lap on the same cycle -> PAUSE, lap_reg unchanged, lap_active = 0.
- PAUSE, clr -> IDLE and a single-cycle cnt_clear; clr pressed in RUN -> no cnt_clear, state stays RUN.
- SATURATE = 1, count_in = 0xFFFF with tick in RUN -> cnt_enable = 0 that cycle, next state PAUSE. With SATURATE = 0 -> cnt_enable = 1, state stays RUN.
- n_rst asserted mid-LAP -> all outputs reach reset values immediately, lap_reg = 0; with STOPWATCH_SYNC_EN, the first press after reset takes effect 3 clk after the edge.
